// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default sizes for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int DEF_NREQ = 2;
    localparam int DEF_AW   = 9;
    localparam int DEF_DW   = 32;
    localparam int STRB_W   = DEF_DW / 8;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection starting at ptr
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   winner
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IW-1:0]     idx;
    logic              found;
    logic [IW:0]       sum;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        dbl    = {req, req} >> ptr;
        rot    = dbl[NREQ-1:0];
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, idx} + {1'b0, ptr};
        if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
        end
        winner = sum[IW-1:0];
        any    = |req;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one valid/ready memory port among NREQ masters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*(DW/8)-1:0]      req_wstrb,
    input  logic [NREQ*AW-1:0]          req_addr,
    input  logic [NREQ*DW-1:0]          req_wdata,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0]             req_err,
    output logic [DW-1:0]               req_rdata,
    output logic                        m_valid,
    output logic [DW/8-1:0]             m_wstrb,
    output logic [AW-1:0]               m_addr,
    output logic [DW-1:0]               m_wdata,
    input  logic                        m_ready,
    input  logic [DW-1:0]               m_rdata,
    output logic                        busy,
    output logic [$clog2(NREQ)-1:0]     grant_id
);

    localparam int IW     = $clog2(NREQ);
    localparam int SW     = DW / 8;
    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_M1  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int TO_SAT = (TIMEOUT > 0) ? TIMEOUT : 0;

    arb_state_t      state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            any;
    logic [IW-1:0]   winner;
    logic            timeout_hit;

    logic            m_valid_nxt;
    logic [SW-1:0]   m_wstrb_nxt;
    logic [AW-1:0]   m_addr_nxt;
    logic [DW-1:0]   m_wdata_nxt;
    logic [NREQ-1:0] req_ready_nxt;
    logic [NREQ-1:0] req_err_nxt;
    logic [DW-1:0]   req_rdata_nxt;
    logic [IW-1:0]   grant_nxt;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req    (req_valid),
        .ptr    (ptr),
        .any    (any),
        .winner (winner)
    );

    assign timeout_hit = (TIMEOUT > 0) && (cnt == CW'(TO_M1));

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt;
        m_valid_nxt   = m_valid;
        m_wstrb_nxt   = m_wstrb;
        m_addr_nxt    = m_addr;
        m_wdata_nxt   = m_wdata;
        req_ready_nxt = '0;
        req_err_nxt   = '0;
        req_rdata_nxt = req_rdata;
        grant_nxt     = grant_id;
        case (state)
            IDLE: begin
                if (any) begin
                    m_wstrb_nxt = req_wstrb[int'(winner)*SW +: SW];
                    m_addr_nxt  = req_addr[int'(winner)*AW +: AW];
                    m_wdata_nxt = req_wdata[int'(winner)*DW +: DW];
                    m_valid_nxt = 1'b1;
                    grant_nxt   = winner;
                    cnt_nxt     = '0;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                // A late m_ready still beats a watchdog expiry in the same cycle.
                if (m_ready || timeout_hit) begin
                    m_valid_nxt             = 1'b0;
                    req_rdata_nxt           = m_ready ? m_rdata : '0;
                    req_ready_nxt[grant_id] = 1'b1;
                    req_err_nxt[grant_id]   = !m_ready;
                    ptr_nxt   = (grant_id == IW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                    state_nxt = DONE;
                end else if (TIMEOUT > 0 && cnt != CW'(TO_SAT)) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            m_valid   <= 1'b0;
            m_wstrb   <= '0;
            m_addr    <= '0;
            m_wdata   <= '0;
            req_ready <= '0;
            req_err   <= '0;
            req_rdata <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            m_valid   <= m_valid_nxt;
            m_wstrb   <= m_wstrb_nxt;
            m_addr    <= m_addr_nxt;
            m_wdata   <= m_wdata_nxt;
            req_ready <= req_ready_nxt;
            req_err   <= req_err_nxt;
            req_rdata <= req_rdata_nxt;
            grant_id  <= grant_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a one-cycle memory model
module tb_mem_port_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*SW-1:0]   req_wstrb = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_err;
    logic [DW-1:0]        req_rdata;
    logic                 m_valid;
    logic [SW-1:0]        m_wstrb;
    logic [AW-1:0]        m_addr;
    logic [DW-1:0]        m_wdata;
    logic                 m_ready = 1'b0;
    logic [DW-1:0]        m_rdata = '0;
    logic                 busy;
    logic [0:0]           grant_id;

    mem_port_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_wstrb (req_wstrb),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .m_valid   (m_valid),
        .m_wstrb   (m_wstrb),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb_q[$];
    int          ready_cyc[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          mv_cnt  = 0;
    int          done_cnt[NREQ];
    bit          hs_prev = 0;
    bit          stall   = 0;
    logic [31:0] mem [0:127];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] rdata, input bit err);
        exp_t e;
        e.id = id; e.rdata = rdata; e.err = err;
        sb_q.push_back(e);
    endtask

    // Memory model: answers one cycle after seeing m_valid, returns the pre-write word.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_valid && !m_ready && !stall) begin
            m_ready <= 1'b1;
            m_rdata <= mem[m_addr[8:2]];
            for (int b = 0; b < SW; b++) begin
                if (m_wstrb[b]) mem[m_addr[8:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            end
        end else begin
            m_ready <= 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (m_valid) mv_cnt++;
        if (m_valid && m_ready) begin
            chk("mvalid_held_after_ready", 32'(hs_prev), 32'd0);
            hs_prev = 1;
        end else begin
            hs_prev = 0;
        end
        if (req_ready != '0) begin
            chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
            if (sb_q.size() == 0) begin
                chk("unexpected_ready", 32'(req_ready), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ready_id", 32'(req_ready), 32'd1 << e.id);
                chk("grant_id", 32'(grant_id), 32'(e.id));
                chk("err", 32'(req_err), e.err ? (32'd1 << e.id) : 32'd0);
                chk("rdata", req_rdata, e.rdata);
                chk("mvalid_low_at_ready", 32'(m_valid), 32'd0);
            end
            ready_cyc.push_back(cyc);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) done_cnt[i]++;
        end
    end

    task automatic start_req(input int id, input logic [3:0] strb, input logic [8:0] addr,
                             input logic [31:0] wdata);
        req_wstrb[id*SW +: SW] = strb;
        req_addr[id*AW +: AW]  = addr;
        req_wdata[id*DW +: DW] = wdata;
        req_valid[id]          = 1'b1;
    endtask

    task automatic wait_done(input int id, input int prev);
        int n = 0;
        while (done_cnt[id] == prev && n < 64) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_cnt[id] == prev) chk($sformatf("wait_ready_%0d", id), 32'd0, 32'd1);
    endtask

    task automatic do_req(input int id, input logic [3:0] strb, input logic [8:0] addr,
                          input logic [31:0] wdata);
        int prev = done_cnt[id];
        start_req(id, strb, addr, wdata);
        wait_done(id, prev);
        req_valid[id] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_wstrb"}, 32'(m_wstrb), 32'd0);
        chk({tag, "_m_addr"}, 32'(m_addr), 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_req_err"}, 32'(req_err), 32'd0);
        chk({tag, "_req_rdata"}, req_rdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int start;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[2] = 32'h00110113;
        mem[3] = 32'hDEADBEEF;
        for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;

        idle_cycles(3);
        chk_all_zero("reset");

        // Contention from reset: both hold req_valid, grants alternate 0,1,0,1.
        push_exp(0, 32'h00110113, 0);
        push_exp(1, 32'hDEADBEEF, 0);
        push_exp(0, 32'h00110113, 0);
        push_exp(1, 32'hDEADBEEF, 0);
        start_req(0, 4'b0000, 9'h008, 32'h0);
        start_req(1, 4'b0000, 9'h00C, 32'h0);
        ready_cyc.delete();
        resetn = 1'b1;
        fork
            begin do_req(0, 4'b0000, 9'h008, 32'h0); do_req(0, 4'b0000, 9'h008, 32'h0); end
            begin do_req(1, 4'b0000, 9'h00C, 32'h0); do_req(1, 4'b0000, 9'h00C, 32'h0); end
        join
        chk("contention_count", 32'(ready_cyc.size()), 32'd4);
        if (ready_cyc.size() == 4) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("contention_gap_%0d", i), 32'(ready_cyc[i+1] - ready_cyc[i]), 32'd4);
        end
        idle_cycles(2);

        // Single read: ready two edges after the sampling edge, m_valid high two cycles.
        push_exp(0, 32'h00110113, 0);
        ready_cyc.delete();
        mv_cnt = 0;
        start = cyc;
        do_req(0, 4'b0000, 9'h008, 32'h0);
        if (ready_cyc.size() > 0) chk("read_latency", 32'(ready_cyc[0] - (start + 1)), 32'd2);
        chk("read_mvalid_cycles", 32'(mv_cnt), 32'd2);
        idle_cycles(2);

        // Partial-strobe write followed by readback.
        push_exp(1, 32'h00000000, 0);
        push_exp(1, 32'h00A500A5, 0);
        do_req(1, 4'b0101, 9'h010, 32'hA5A5A5A5);
        idle_cycles(1);
        do_req(1, 4'b0000, 9'h010, 32'h0);
        idle_cycles(2);

        // Late requester: 1 arrives during 0's DONE cycle and wins the next IDLE.
        push_exp(0, 32'h00110113, 0);
        push_exp(1, 32'hDEADBEEF, 0);
        start_req(0, 4'b0000, 9'h008, 32'h0);
        wait_done(0, done_cnt[0]);
        start = done_cnt[1];
        start_req(1, 4'b0000, 9'h00C, 32'h0);
        idle_cycles(1);
        req_valid[0] = 1'b0;
        wait_done(1, start);
        req_valid[1] = 1'b0;
        idle_cycles(2);

        // Watchdog: memory never answers, abort after four WAIT cycles with err.
        stall = 1;
        push_exp(1, 32'h00000000, 1);
        mv_cnt = 0;
        do_req(1, 4'b0000, 9'h008, 32'h0);
        chk("timeout_mvalid_cycles", 32'(mv_cnt), 32'd4);
        stall = 0;
        idle_cycles(2);
        // ptr returned to 0 after the abort: requester 0 wins the next contention.
        push_exp(0, 32'h00110113, 0);
        push_exp(1, 32'hDEADBEEF, 0);
        fork
            do_req(0, 4'b0000, 9'h008, 32'h0);
            do_req(1, 4'b0000, 9'h00C, 32'h0);
        join
        idle_cycles(2);

        // Reset one cycle after a grant: transaction abandoned, no ready.
        start_req(1, 4'b0000, 9'h00C, 32'h0);
        idle_cycles(1);
        chk("pre_reset_mvalid", 32'(m_valid), 32'd1);
        chk("pre_reset_grant", 32'(grant_id), 32'd1);
        resetn = 1'b0;
        idle_cycles(1);
        chk_all_zero("midreset");
        resetn = 1'b1;
        req_valid = '0;
        idle_cycles(4);
        push_exp(0, 32'h00110113, 0);
        do_req(0, 4'b0000, 9'h008, 32'h0);
        idle_cycles(3);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
